// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state encoding and field limits for the time-of-day core
package clock_pkg;

    typedef enum logic [2:0] {
        STOPPED = 3'd0,
        RUNNING = 3'd1,
        SET_HR  = 3'd2,
        SET_MIN = 3'd3,
        SET_SEC = 3'd4
    } state_t;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    function automatic logic is_set_state(input state_t s);
        return (s == SET_HR) || (s == SET_MIN) || (s == SET_SEC);
    endfunction

endpackage

// File: rtl/bcd_split.sv
// rtl/bcd_split.sv - combinational binary 0..59 to tens/ones BCD digit pair
module bcd_split (
    input  logic [5:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    logic [5:0] tens_w;
    logic [5:0] ones_w;

    assign tens_w = bin_i / 6'd10;
    assign ones_w = bin_i % 6'd10;
    assign tens_o = tens_w[3:0];
    assign ones_o = ones_w[3:0];

endmodule

// File: rtl/clock_core.sv
// rtl/clock_core.sv - prescaled HH:MM:SS clock with run/stop, field setting, 12/24h display and set-mode blink
import clock_pkg::*;

module clock_core #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BLINK_HZ    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_toggle,
    input  logic       mode_pulse,
    input  logic       inc_pulse,
    input  logic       fmt_12h,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] hr_tens,
    output logic [5:0] blank,
    output logic       pm,
    output logic       running,
    output logic       tick_1hz,
    output logic       day_wrap
);

    localparam int PW         = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam int HALF       = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int BW         = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_FREQ_HZ - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;

    logic          inc_ok;
    logic [4:0]    hour_disp;

    assign tick_1hz = (state_q == RUNNING) && (pre_q == PRE_MAX);
    assign day_wrap = tick_1hz && (sec_q == SEC_MAX) && (min_q == MIN_MAX) && (hour_q == HOUR_MAX);
    // A pulse of higher priority in the same cycle swallows the increment.
    assign inc_ok   = inc_pulse && !mode_pulse && !run_toggle;

    always_comb begin
        state_d = state_q;
        if (mode_pulse) begin
            case (state_q)
                STOPPED, RUNNING: state_d = SET_HR;
                SET_HR:           state_d = SET_MIN;
                SET_MIN:          state_d = SET_SEC;
                default:          state_d = STOPPED;
            endcase
        end else if (run_toggle) begin
            if (state_q == STOPPED)      state_d = RUNNING;
            else if (state_q == RUNNING) state_d = STOPPED;
        end
    end

    always_comb begin
        pre_d = pre_q;
        if (mode_pulse && (state_d == SET_HR)) pre_d = '0;
        else if (tick_1hz)                     pre_d = '0;
        else if (state_q == RUNNING)           pre_d = pre_q + 1'b1;
    end

    // Ticks use carries; set-mode increments wrap within their own field only.
    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (tick_1hz) begin
            sec_d = (sec_q == SEC_MAX) ? 6'd0 : sec_q + 6'd1;
            if (sec_q == SEC_MAX) begin
                min_d = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
                if (min_q == MIN_MAX) hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
            end
        end else if (inc_ok) begin
            case (state_q)
                SET_HR:  hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
                SET_MIN: min_d  = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
                SET_SEC: sec_d  = (sec_q == SEC_MAX) ? 6'd0 : sec_q + 6'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_off_d = blink_off_q;
        if (mode_pulse || inc_ok || !is_set_state(state_q)) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            blink_off_d = !blink_off_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= STOPPED;
            pre_q       <= '0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
        end
    end

    always_comb begin
        hour_disp = hour_q;
        if (fmt_12h) begin
            if (hour_q == 5'd0)       hour_disp = 5'd12;
            else if (hour_q > 5'd12)  hour_disp = hour_q - 5'd12;
        end
    end

    always_comb begin
        blank = 6'b000000;
        if (blink_off_q) begin
            case (state_q)
                SET_HR:  blank = 6'b110000;
                SET_MIN: blank = 6'b001100;
                SET_SEC: blank = 6'b000011;
                default: blank = 6'b000000;
            endcase
        end
    end

    assign pm      = (hour_q >= 5'd12);
    assign running = (state_q == RUNNING);

    bcd_split u_sec (.bin_i(sec_q),              .tens_o(sec_tens), .ones_o(sec_ones));
    bcd_split u_min (.bin_i(min_q),              .tens_o(min_tens), .ones_o(min_ones));
    bcd_split u_hr  (.bin_i({1'b0, hour_disp}),  .tens_o(hr_tens),  .ones_o(hr_ones));

endmodule
